dram_arbiter: RTL and testbench

- Two-requester controller for the two-phase DRAM model (address latched on clk2 rising edge, read/write executed on clk1 rising edge).
- Generates the clk1/clk2 phase strobes from one system clock.
- Round-robin arbitrates two requesters (p0, p1) onto the single DRAM port and sequences address, command and data phases.
- Sustains one transaction per 4-cycle slot; returns read data with a done pulse.

---
 rtl/dram_pkg.sv | 17 +
 rtl/dram_arbiter_phase_gen.sv | 41 ++++
 rtl/dram_arbiter.sv | 142 ++++++++++++++
 tb/tb_dram_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types and constants for the two-phase DRAM arbiter.
// The phase numbering follows the 4-cycle slot: data strobe, grant/done, address strobe, command.
package dram_pkg;

    localparam int WORD_SIZE_DEF  = 16;
    localparam int ADDR_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        PH_DATA       = 2'd0,
        PH_SAMPLE_OUT = 2'd1,
        PH_ADDR       = 2'd2,
        PH_CMD        = 2'd3
    } phase_e;

    typedef logic port_id_t;

endpackage

// File: rtl/dram_arbiter_phase_gen.sv
// Free-running 2-bit phase counter producing registered clk1/clk2 strobes.
// The decodes tell the datapath which phase is ending on the current edge.
module dram_phase_gen
    import dram_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    output phase_e ph_o,
    output logic   clk1_o,
    output logic   clk2_o,
    output logic   sample_edge_o,
    output logic   cmd_edge_o
);

    phase_e ph_q;
    phase_e ph_d;
    logic   clk1_q;
    logic   clk2_q;

    assign ph_d = phase_e'(ph_q + 2'd1);

    // Strobes decode the next phase so the flop output is high exactly during that phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q   <= PH_CMD;
            clk1_q <= 1'b0;
            clk2_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            clk1_q <= (ph_d == PH_DATA);
            clk2_q <= (ph_d == PH_ADDR);
        end
    end

    assign ph_o          = ph_q;
    assign clk1_o        = clk1_q;
    assign clk2_o        = clk2_q;
    assign sample_edge_o = (ph_q == PH_DATA);
    assign cmd_edge_o    = (ph_q == PH_ADDR);

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin two-port controller for a two-phase DRAM: one transaction per 4-cycle slot.
// Handshake: req+payload held until a one-cycle gnt; a done pulse follows 4 cycles later.
module dram_arbiter
    import dram_pkg::*;
#(
    parameter int WordSize  = WORD_SIZE_DEF,
    parameter int AddrWidth = ADDR_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [AddrWidth-1:0] p0_addr,
    input  logic [WordSize-1:0]  p0_wdata,
    output logic                 p0_gnt,
    output logic                 p0_done,
    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [AddrWidth-1:0] p1_addr,
    input  logic [WordSize-1:0]  p1_wdata,
    output logic                 p1_gnt,
    output logic                 p1_done,
    output logic [WordSize-1:0]  rdata,
    output logic                 mem_clk1,
    output logic                 mem_clk2,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [WordSize-1:0]  mem_din,
    output logic                 mem_rd,
    output logic                 mem_wr,
    input  logic [WordSize-1:0]  mem_dout
);

    phase_e ph;
    logic   sample_edge;
    logic   cmd_edge;

    dram_phase_gen u_phase_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .ph_o          (ph),
        .clk1_o        (mem_clk1),
        .clk2_o        (mem_clk2),
        .sample_edge_o (sample_edge),
        .cmd_edge_o    (cmd_edge)
    );

    logic                 grant_d;
    port_id_t             win_d;
    logic                 sel_we_d;
    logic [AddrWidth-1:0] sel_addr_d;
    logic [WordSize-1:0]  sel_wdata_d;

    port_id_t             prio_q;
    logic                 busy_q;
    port_id_t             owner_q;
    logic                 we_q;
    logic [WordSize-1:0]  wdata_q;
    logic                 gnt0_q, gnt1_q, done0_q, done1_q;
    logic [WordSize-1:0]  rdata_q;
    logic [AddrWidth-1:0] mem_addr_q;
    logic [WordSize-1:0]  mem_din_q;
    logic                 mem_rd_q, mem_wr_q;

    // prio_q names the port that wins a tie; it flips away from each winner.
    always_comb begin
        grant_d = 1'b0;
        win_d   = 1'b0;
        if (p0_req && p1_req) begin
            grant_d = 1'b1;
            win_d   = prio_q;
        end else if (p0_req) begin
            grant_d = 1'b1;
            win_d   = 1'b0;
        end else if (p1_req) begin
            grant_d = 1'b1;
            win_d   = 1'b1;
        end
        sel_we_d    = win_d ? p1_we    : p0_we;
        sel_addr_d  = win_d ? p1_addr  : p0_addr;
        sel_wdata_d = win_d ? p1_wdata : p0_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q     <= 1'b0;
            busy_q     <= 1'b0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            if (sample_edge) begin
                // Retire the slot whose clk1 just fired, then load the new winner.
                if (busy_q) begin
                    if (owner_q) done1_q <= 1'b1;
                    else         done0_q <= 1'b1;
                    if (!we_q) rdata_q <= mem_dout;
                end
                mem_rd_q <= 1'b0;
                mem_wr_q <= 1'b0;
                busy_q   <= grant_d;
                if (grant_d) begin
                    owner_q    <= win_d;
                    we_q       <= sel_we_d;
                    wdata_q    <= sel_wdata_d;
                    mem_addr_q <= sel_addr_d;
                    prio_q     <= ~win_d;
                    if (win_d) gnt1_q <= 1'b1;
                    else       gnt0_q <= 1'b1;
                end
            end
            if (cmd_edge && busy_q) begin
                mem_rd_q  <= ~we_q;
                mem_wr_q  <= we_q;
                mem_din_q <= wdata_q;
            end
        end
    end

    assign p0_gnt   = gnt0_q;
    assign p1_gnt   = gnt1_q;
    assign p0_done  = done0_q;
    assign p1_done  = done1_q;
    assign rdata    = rdata_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural two-phase DRAM attached.
module tb_dram_arbiter;

    localparam int W = 16;
    localparam int A = 16;

    logic         clk, rst_n;
    logic         p0_req, p0_we, p1_req, p1_we;
    logic [A-1:0] p0_addr, p1_addr;
    logic [W-1:0] p0_wdata, p1_wdata;
    logic         p0_gnt, p0_done, p1_gnt, p1_done;
    logic [W-1:0] rdata;
    logic         mem_clk1, mem_clk2, mem_rd, mem_wr;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_din, mem_dout;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [1:0]   tb_ph;

    dram_arbiter #(.WordSize(W), .AddrWidth(A)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done),
        .rdata(rdata), .mem_clk1(mem_clk1), .mem_clk2(mem_clk2),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_dout(mem_dout)
    );

    // Clock and reset-aware phase reference.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ph <= 2'd3;
        else        tb_ph <= tb_ph + 2'd1;
    end

    // Two-phase DRAM: address latched on clk2, read/write on clk1.
    logic [W-1:0] dram_mem [0:255];
    logic [A-1:0] lat_addr;
    logic [W-1:0] dout_r;
    assign mem_dout = dout_r;

    always @(posedge mem_clk2) lat_addr = mem_addr;
    always @(posedge mem_clk1) begin
        if (mem_wr) dram_mem[lat_addr[7:0]] = mem_din;
        if (mem_rd) dout_r = dram_mem[lat_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Strobe pattern and command exclusivity on every cycle.
    always @(negedge clk) begin
        check("clk1_phase", mem_clk1, tb_ph == 2'd0);
        check("clk2_phase", mem_clk2, tb_ph == 2'd2);
        check("rd_wr_excl", mem_rd & mem_wr, 1'b0);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ph(input logic [1:0] p);
        for (int n = 0; n < 8 && tb_ph != p; n++) tick();
    endtask

    task automatic drive(input bit port, input logic req, input logic we,
                         input logic [A-1:0] addr, input logic [W-1:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic check_rdata(input string tag);
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
        else check(tag, rdata, exp_q.pop_front());
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // Pipelined pair of p0 reads; rdata must hold between the two done pulses.
    task automatic rd_pair(input logic [A-1:0] a0, input logic [W-1:0] e0,
                           input logic [A-1:0] a1, input logic [W-1:0] e1);
        wait_ph(2'd0);
        drive(0, 1, 0, a0, 16'h0);
        tick();
        check("pair_gnt0", p0_gnt, 1);
        exp_q.push_back(e0);
        p0_addr = a1;
        repeat (4) tick();
        check("pair_gnt1", p0_gnt, 1);
        check("pair_done0", p0_done, 1);
        check_rdata("pair_rdata0");
        exp_q.push_back(e1);
        p0_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pair_hold", rdata, e0);
            check("pair_no_done", p0_done, 0);
        end
        tick();
        check("pair_done1", p0_done, 1);
        check_rdata("pair_rdata1");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dram_mem[i] = '0;
        dram_mem[8'h0A] = 16'h1234;
        dram_mem[8'h01] = 16'hA5A5;
        dout_r = 'x;
        rst_n = 1'b0;
        drive(0, 0, 0, 16'h0, 16'h0);
        drive(1, 0, 0, 16'h0, 16'h0);

        // Reset values, then the strobe sequence with no requests.
        tick(); tick();
        check("rst_clk1", mem_clk1, 0);
        check("rst_clk2", mem_clk2, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_din", mem_din, 0);
        check("rst_rdata", rdata, 0);
        check("rst_gnt", {p0_gnt, p1_gnt, p0_done, p1_done}, 0);
        rst_n = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            check("seq_clk1", mem_clk1, (cyc % 4) == 1);
            check("seq_clk2", mem_clk2, (cyc % 4) == 3);
            check("idle_cmd", {mem_rd, mem_wr}, 0);
        end

        // p1 writes 0x06CF to 2, p0 reads it back in the next slot.
        wait_ph(2'd0);
        drive(1, 1, 1, 16'h0002, 16'h06CF);
        tick();
        check("w_gnt1", p1_gnt, 1);
        check("w_gnt0", p0_gnt, 0);
        drive(1, 0, 0, 16'h0, 16'h0);
        drive(0, 1, 0, 16'h0002, 16'h0);
        exp_q.push_back(16'h06CF);
        tick();
        check("w_addr", mem_addr, 16'h0002);
        tick();
        check("w_cmd_ph3", {mem_rd, mem_wr}, 2'b01);
        check("w_din", mem_din, 16'h06CF);
        tick();
        check("w_cmd_ph0", {mem_rd, mem_wr}, 2'b01);
        tick();
        check("w_done1", p1_done, 1);
        check("r_gnt0", p0_gnt, 1);
        p0_req = 1'b0;
        tick();
        check("r_cmd_ph2", {mem_rd, mem_wr}, 2'b00);
        tick();
        check("r_cmd_ph3", {mem_rd, mem_wr}, 2'b10);
        tick();
        check("r_cmd_ph0", {mem_rd, mem_wr}, 2'b10);
        tick();
        check("r_done0", p0_done, 1);
        check("r_done1", p1_done, 0);
        check_rdata("r_rdata");

        // Both ports request continuously from reset: p0 wins the first tie.
        apply_reset();
        wait_ph(2'd0);
        drive(0, 1, 0, 16'h000A, 16'h0);
        drive(1, 1, 0, 16'h0001, 16'h0);
        for (int k = 0; k <= 4; k++) begin
            tick();
            check("alt_gnt0", p0_gnt, (k < 4) && (k % 2 == 0));
            check("alt_gnt1", p1_gnt, (k < 4) && (k % 2 == 1));
            if (k < 4) exp_q.push_back((k % 2 == 0) ? 16'h1234 : 16'hA5A5);
            if (k >= 1) begin
                check("alt_done0", p0_done, (k - 1) % 2 == 0);
                check("alt_done1", p1_done, (k - 1) % 2 == 1);
                check_rdata("alt_rdata");
            end
            if (k == 3) begin
                p0_req = 1'b0;
                p1_req = 1'b0;
            end
            if (k < 4) repeat (3) tick();
        end

        // Request raised in ph2 waits for the next sample edge; payload taken there.
        wait_ph(2'd2);
        drive(0, 1, 0, 16'h000A, 16'h0);
        tick();
        check("late_gnt_ph3", p0_gnt, 0);
        tick();
        check("late_gnt_ph0", p0_gnt, 0);
        p0_addr = 16'h0001;
        tick();
        check("late_gnt_ph1", p0_gnt, 1);
        exp_q.push_back(16'hA5A5);
        p0_req = 1'b0;
        tick();
        check("late_addr", mem_addr, 16'h0001);
        repeat (3) tick();
        check("late_done", p0_done, 1);
        check_rdata("late_rdata");

        // Reset during ph3 of a p0 write: everything drops, no done, memory untouched.
        wait_ph(2'd0);
        drive(0, 1, 1, 16'h0005, 16'hBEEF);
        tick();
        check("abort_gnt", p0_gnt, 1);
        p0_req = 1'b0;
        tick(); tick();
        check("abort_wr_before", mem_wr, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cmd", {mem_rd, mem_wr}, 0);
        check("abort_strobes", {mem_clk1, mem_clk2}, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_din", mem_din, 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", p0_done, 0);
        end
        rd_pair(16'h000A, 16'h1234, 16'h0005, 16'h0000);

        // Back-to-back reads of preloaded locations.
        rd_pair(16'h000A, 16'h1234, 16'h0001, 16'hA5A5);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
